// File: rtl/alu_ctrl_exec.sv
// rtl/alu_ctrl_exec.sv - EX-stage ALU with ALUop/func decode, registered result and iterative MULTU
module alu_ctrl_exec #(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       alu_op,
    input  logic [5:0]       func,
    input  logic [SHW-1:0]   shamt,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             illegal
);

    // Counter must hold the value WIDTH itself, hence one extra bit.
    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_MUL  = 1'b1
    } state_t;

    typedef enum logic [3:0] {
        OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NOR, OP_SLT,
        OP_SLL, OP_SRL, OP_SRA, OP_MULTU, OP_MFHI, OP_MFLO, OP_ILL
    } op_t;

    state_t             r_state;
    state_t             w_state_next;
    op_t                w_op;
    logic               w_accept;
    logic               w_mul_last;
    logic               w_slt;
    logic [WIDTH-1:0]   w_alu_res;
    logic [WIDTH:0]     w_mul_sum;
    logic [2*WIDTH-1:0] w_prod_next;

    logic [2*WIDTH-1:0] r_prod;
    logic [WIDTH-1:0]   r_mcand;
    logic [CW-1:0]      r_count;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic               r_out_valid;
    logic [WIDTH-1:0]   r_result;
    logic               r_zero;
    logic               r_illegal;

    assign in_ready   = (r_state == S_IDLE);
    assign w_accept   = in_valid & in_ready;
    assign w_mul_last = (r_state == S_MUL) && (r_count == CW'(1));
    assign w_slt      = ($signed(a) < $signed(b));

    assign out_valid  = r_out_valid;
    assign result     = r_result;
    assign zero       = r_zero;
    assign illegal    = r_illegal;

    // Decode ALUop, falling through to the funct field for R-type (01x).
    always_comb begin
        w_op = OP_ILL;
        casez (alu_op)
            3'b000:  w_op = OP_ADD;
            3'b001:  w_op = OP_SUB;
            3'b100:  w_op = OP_AND;
            3'b101:  w_op = OP_OR;
            3'b110:  w_op = OP_SLT;
            3'b111:  w_op = OP_ILL;
            3'b01?: begin
                case (func)
                    6'b100000: w_op = OP_ADD;
                    6'b100010: w_op = OP_SUB;
                    6'b100100: w_op = OP_AND;
                    6'b100101: w_op = OP_OR;
                    6'b100110: w_op = OP_XOR;
                    6'b100111: w_op = OP_NOR;
                    6'b101010: w_op = OP_SLT;
                    6'b000000: w_op = OP_SLL;
                    6'b000010: w_op = OP_SRL;
                    6'b000011: w_op = OP_SRA;
                    6'b011001: w_op = OP_MULTU;
                    6'b010000: w_op = OP_MFHI;
                    6'b010010: w_op = OP_MFLO;
                    default:   w_op = OP_ILL;
                endcase
            end
            default: w_op = OP_ILL;
        endcase
    end

    // Single-cycle result; illegal and MULTU produce zero here (MULTU result comes later).
    always_comb begin
        w_alu_res = '0;
        case (w_op)
            OP_ADD:  w_alu_res = a + b;
            OP_SUB:  w_alu_res = a - b;
            OP_AND:  w_alu_res = a & b;
            OP_OR:   w_alu_res = a | b;
            OP_XOR:  w_alu_res = a ^ b;
            OP_NOR:  w_alu_res = ~(a | b);
            OP_SLT:  w_alu_res = {{(WIDTH-1){1'b0}}, w_slt};
            OP_SLL:  w_alu_res = b << shamt;
            OP_SRL:  w_alu_res = b >> shamt;
            OP_SRA:  w_alu_res = WIDTH'($signed(b) >>> shamt);
            OP_MFHI: w_alu_res = r_hi;
            OP_MFLO: w_alu_res = r_lo;
            default: w_alu_res = '0;
        endcase
    end

    // Radix-2 shift-add step: add multiplicand into the upper half when the
    // current multiplier LSB is set, then shift the whole product right by one.
    always_comb begin
        w_mul_sum   = {1'b0, r_prod[2*WIDTH-1:WIDTH]};
        if (r_prod[0]) begin
            w_mul_sum = {1'b0, r_prod[2*WIDTH-1:WIDTH]} + {1'b0, r_mcand};
        end
        w_prod_next = {w_mul_sum, r_prod[WIDTH-1:1]};
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state: IDLE leaves only for MULTU, MUL returns on the last step.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (w_accept && (w_op == OP_MULTU)) w_state_next = S_MUL;
            S_MUL:   if (w_mul_last) w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // Datapath: result/flags on accept, multiplier iteration and HI/LO writeback.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prod      <= '0;
            r_mcand     <= '0;
            r_count     <= '0;
            r_hi        <= '0;
            r_lo        <= '0;
            r_out_valid <= 1'b0;
            r_result    <= '0;
            r_zero      <= 1'b0;
            r_illegal   <= 1'b0;
        end else begin
            r_out_valid <= 1'b0;
            if (w_accept) begin
                if (w_op == OP_MULTU) begin
                    r_count <= CW'(WIDTH);
                    r_prod  <= {{WIDTH{1'b0}}, b};
                    r_mcand <= a;
                end else begin
                    r_out_valid <= 1'b1;
                    r_result    <= w_alu_res;
                    r_zero      <= (w_alu_res == '0);
                    r_illegal   <= (w_op == OP_ILL);
                end
            end else if (r_state == S_MUL) begin
                r_prod  <= w_prod_next;
                r_count <= r_count - CW'(1);
                if (w_mul_last) begin
                    r_hi        <= w_prod_next[2*WIDTH-1:WIDTH];
                    r_lo        <= w_prod_next[WIDTH-1:0];
                    r_result    <= w_prod_next[WIDTH-1:0];
                    r_zero      <= (w_prod_next[WIDTH-1:0] == '0);
                    r_illegal   <= 1'b0;
                    r_out_valid <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_alu_ctrl_exec.sv
// tb/tb_alu_ctrl_exec.sv - randomized self-checking bench for alu_ctrl_exec against a mnemonic-level model
module tb_alu_ctrl_exec;

    localparam int WIDTH = 32;
    localparam int SHW   = 5;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       alu_op;
    logic [5:0]       func;
    logic [SHW-1:0]   shamt;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             illegal;

    int n_cmp;
    int n_err;

    logic [WIDTH-1:0] m_hi;
    logic [WIDTH-1:0] m_lo;

    alu_ctrl_exec #(.WIDTH(WIDTH), .SHW(SHW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .alu_op    (alu_op),
        .func      (func),
        .shamt     (shamt),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .result    (result),
        .zero      (zero),
        .illegal   (illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic string op_name(input logic [2:0] op, input logic [5:0] f);
        if (op == 3'b000) return "ADD";
        if (op == 3'b001) return "SUB";
        if (op == 3'b100) return "AND";
        if (op == 3'b101) return "OR";
        if (op == 3'b110) return "SLT";
        if (op == 3'b111) return "ILL";
        case (f)
            6'h20: return "ADD";
            6'h22: return "SUB";
            6'h24: return "AND";
            6'h25: return "OR";
            6'h26: return "XOR";
            6'h27: return "NOR";
            6'h2A: return "SLT";
            6'h00: return "SLL";
            6'h02: return "SRL";
            6'h03: return "SRA";
            6'h19: return "MULTU";
            6'h10: return "MFHI";
            6'h12: return "MFLO";
            default: return "ILL";
        endcase
    endfunction

    function automatic logic [WIDTH-1:0] ref_exec(input string n, input logic [WIDTH-1:0] x,
                                                 input logic [WIDTH-1:0] y, input int sh);
        longint sx, sy;
        longint unsigned prod;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        prod = longint'(x) * longint'(y);
        if (n == "ADD")   return WIDTH'(longint'(x) + longint'(y));
        if (n == "SUB")   return WIDTH'(longint'(x) - longint'(y));
        if (n == "AND")   return x & y;
        if (n == "OR")    return x | y;
        if (n == "XOR")   return x ^ y;
        if (n == "NOR")   return ~(x | y);
        if (n == "SLT")   return (sx < sy) ? 1 : 0;
        if (n == "SLL")   return WIDTH'(longint'(y) * (longint'(1) << sh));
        if (n == "SRL")   return WIDTH'(longint'(y) / (longint'(1) << sh));
        if (n == "SRA")   return WIDTH'(sy >>> sh);
        if (n == "MULTU") return prod[WIDTH-1:0];
        if (n == "MFHI")  return m_hi;
        if (n == "MFLO")  return m_lo;
        return '0;
    endfunction

    task automatic issue(input logic [2:0] op, input logic [5:0] f, input logic [SHW-1:0] sh,
                         input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
        in_valid = 1'b1;
        alu_op   = op;
        func     = f;
        shamt    = sh;
        a        = x;
        b        = y;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        n_cmp++; if (result !== '0) begin n_err++; $display("FAIL reset_result got=%h exp=0", result); end
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        n_cmp++; if (illegal !== 1'b0 || zero !== 1'b0) begin n_err++; $display("FAIL reset_flags got=%b%b exp=00", illegal, zero); end
        rst_n = 1'b1;
        issue(3'b010, 6'h19, '0, 32'h1234_5678, 32'h9ABC_DEF0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        n_cmp++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || result !== '0) begin
            n_err++; $display("FAIL reset_mid_op got ov=%b rdy=%b res=%h exp ov=0 rdy=1 res=0", out_valid, in_ready, result);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        m_hi = '0;
        m_lo = '0;
        issue(3'b010, 6'h12, '0, '0, '0);
        n_cmp++; if (out_valid !== 1'b1 || result !== '0 || zero !== 1'b1) begin
            n_err++; $display("FAIL reset_mflo got ov=%b res=%h z=%b exp ov=1 res=0 z=1", out_valid, result, zero);
        end
        issue(3'b010, 6'h10, '0, '0, '0);
        n_cmp++; if (result !== '0) begin n_err++; $display("FAIL reset_mfhi got=%h exp=0", result); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_decode_sweep();
        logic [2:0]       t_op  [15] = '{3'b000, 3'b001, 3'b100, 3'b101, 3'b010, 3'b010, 3'b011, 3'b010,
                                         3'b010, 3'b011, 3'b010, 3'b010, 3'b010, 3'b011, 3'b110};
        logic [5:0]       t_fn  [15] = '{6'h3F, 6'h3F, 6'h3F, 6'h3F, 6'h20, 6'h22, 6'h24, 6'h25,
                                         6'h26, 6'h27, 6'h2A, 6'h00, 6'h02, 6'h03, 6'h00};
        logic [WIDTH-1:0] t_exp [15] = '{32'hFF, 32'hE1, 32'h0, 32'hFF, 32'hFF, 32'hE1, 32'h0, 32'hFF,
                                         32'hFF, 32'hFFFF_FF00, 32'h0, 32'h0, 32'h0800_0000, 32'hF800_0000, 32'h0};
        logic [WIDTH-1:0] bv;
        for (int i = 0; i < 15; i++) begin
            bv = (i >= 11 && i <= 13) ? 32'h8000_0000 : 32'h0000_000F;
            issue(t_op[i], t_fn[i], 5'd4, 32'h0000_00F0, bv);
            n_cmp++; if (out_valid !== 1'b1 || result !== t_exp[i] || zero !== (t_exp[i] == 0) || illegal !== 1'b0) begin
                n_err++; $display("FAIL sweep_%0d got ov=%b res=%h z=%b ill=%b exp ov=1 res=%h", i, out_valid, result, zero, illegal, t_exp[i]);
            end
            @(posedge clk);
            #1;
            n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL sweep_pulse_%0d got=%b exp=0", i, out_valid); end
        end
    endtask

    task automatic test_slt();
        logic [2:0] ops [2] = '{3'b010, 3'b110};
        for (int i = 0; i < 2; i++) begin
            issue(ops[i], 6'h2A, '0, 32'hFFFF_FFFF, 32'h1);
            n_cmp++; if (result !== 32'h1 || zero !== 1'b0) begin n_err++; $display("FAIL slt_neg_%0d got=%h exp=1", i, result); end
            issue(ops[i], 6'h2A, '0, 32'h1, 32'hFFFF_FFFF);
            n_cmp++; if (result !== 32'h0 || zero !== 1'b1) begin n_err++; $display("FAIL slt_swap_%0d got=%h z=%b exp=0 z=1", i, result, zero); end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_multu();
        int cyc;
        int busy;
        int pulses;
        issue(3'b010, 6'h19, '0, 32'hFFFF_FFFF, 32'h0000_0002);
        cyc = 0;
        busy = 0;
        while (out_valid !== 1'b1 && cyc < WIDTH + 8) begin
            if (in_ready === 1'b0) busy++;
            @(posedge clk);
            #1;
            cyc++;
        end
        n_cmp++; if (cyc !== WIDTH) begin n_err++; $display("FAIL multu_latency got=%0d exp=%0d", cyc, WIDTH); end
        n_cmp++; if (busy !== WIDTH) begin n_err++; $display("FAIL multu_busy got=%0d exp=%0d", busy, WIDTH); end
        n_cmp++; if (result !== 32'hFFFF_FFFE || in_ready !== 1'b1) begin
            n_err++; $display("FAIL multu_lo got=%h rdy=%b exp=fffffffe rdy=1", result, in_ready);
        end
        m_hi = 32'h1;
        m_lo = 32'hFFFF_FFFE;
        @(posedge clk);
        #1;
        issue(3'b010, 6'h10, '0, '0, '0);
        n_cmp++; if (result !== 32'h1) begin n_err++; $display("FAIL multu_mfhi got=%h exp=00000001", result); end

        // Requester holds an ADD during the busy window; only the out_valid cycle can accept it.
        issue(3'b010, 6'h19, '0, 32'd7, 32'd6);
        in_valid = 1'b1; alu_op = 3'b000; a = 32'd1; b = 32'd2;
        pulses = 0;
        cyc = 0;
        while (out_valid !== 1'b1 && cyc < WIDTH + 8) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        n_cmp++; if (result !== 32'd42) begin n_err++; $display("FAIL hold_mul_res got=%h exp=2a", result); end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        n_cmp++; if (out_valid !== 1'b1 || result !== 32'd3) begin
            n_err++; $display("FAIL hold_add got ov=%b res=%h exp ov=1 res=3", out_valid, result);
        end
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            if (out_valid === 1'b1) pulses++;
        end
        n_cmp++; if (pulses !== 0) begin n_err++; $display("FAIL hold_extra got=%0d exp=0", pulses); end
        m_hi = 32'h0;
        m_lo = 32'd42;
    endtask

    task automatic test_illegal();
        logic [2:0] iop [2] = '{3'b111, 3'b010};
        for (int i = 0; i < 2; i++) begin
            issue(iop[i], 6'h3F, '0, 32'h5, 32'h6);
            n_cmp++; if (out_valid !== 1'b1 || illegal !== 1'b1 || result !== '0 || zero !== 1'b1) begin
                n_err++; $display("FAIL illegal_%0d got ov=%b ill=%b res=%h z=%b exp 1 1 0 1", i, out_valid, illegal, result, zero);
            end
        end
        issue(3'b010, 6'h12, '0, '0, '0);
        n_cmp++; if (result !== m_lo) begin n_err++; $display("FAIL illegal_lo_kept got=%h exp=%h", result, m_lo); end
        issue(3'b111, 6'h00, '0, '0, '0);
        issue(3'b000, 6'h00, '0, 32'd10, 32'd20);
        n_cmp++; if (illegal !== 1'b0 || result !== 32'd30) begin
            n_err++; $display("FAIL illegal_clear got ill=%b res=%h exp ill=0 res=1e", illegal, result);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_random();
        logic [5:0] legal [13] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A,
                                   6'h00, 6'h02, 6'h03, 6'h19, 6'h10, 6'h12};
        logic [2:0]       op;
        logic [5:0]       f;
        logic [SHW-1:0]   sh;
        logic [WIDTH-1:0] x, y, exp_r;
        longint unsigned  prod;
        string            n;
        int               cyc;
        for (int i = 0; i < 150; i++) begin
            op = 3'($urandom_range(0, 7));
            f  = ($urandom_range(0, 9) < 8) ? legal[$urandom_range(0, 12)] : 6'($urandom);
            sh = SHW'($urandom);
            x  = $urandom;
            y  = $urandom;
            if ($urandom_range(0, 7) == 0) y = x;
            n = op_name(op, f);
            exp_r = ref_exec(n, x, y, int'(sh));
            issue(op, f, sh, x, y);
            if (n == "MULTU") begin
                prod = longint'(x) * longint'(y);
                cyc = 0;
                while (out_valid !== 1'b1 && cyc < WIDTH + 8) begin
                    @(posedge clk);
                    #1;
                    cyc++;
                end
                m_hi = prod[2*WIDTH-1:WIDTH];
                m_lo = prod[WIDTH-1:0];
            end
            n_cmp++; if (out_valid !== 1'b1 || result !== exp_r || zero !== (exp_r == 0) || illegal !== (n == "ILL")) begin
                n_err++; $display("FAIL rand_%0d_%s got ov=%b res=%h z=%b ill=%b exp res=%h", i, n, out_valid, result, zero, illegal, exp_r);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset_mid_mul();
        int pulses;
        issue(3'b010, 6'h19, '0, 32'hDEAD_BEEF, 32'h0000_1234);
        repeat (9) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        n_cmp++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_err++; $display("FAIL midmul_reset got rdy=%b ov=%b exp rdy=1 ov=0", in_ready, out_valid);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        m_hi = '0;
        m_lo = '0;
        pulses = 0;
        for (int i = 0; i < WIDTH + 4; i++) begin
            @(posedge clk);
            #1;
            if (out_valid === 1'b1) pulses++;
        end
        n_cmp++; if (pulses !== 0) begin n_err++; $display("FAIL midmul_no_out got=%0d exp=0", pulses); end
        issue(3'b010, 6'h12, '0, '0, '0);
        n_cmp++; if (out_valid !== 1'b1 || result !== '0 || zero !== 1'b1) begin
            n_err++; $display("FAIL midmul_mflo got ov=%b res=%h exp ov=1 res=0", out_valid, result);
        end
        issue(3'b010, 6'h10, '0, '0, '0);
        n_cmp++; if (result !== '0) begin n_err++; $display("FAIL midmul_mfhi got=%h exp=0", result); end
    endtask

    initial begin
        n_cmp    = 0;
        n_err    = 0;
        m_hi     = '0;
        m_lo     = '0;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        alu_op   = '0;
        func     = '0;
        shamt    = '0;
        a        = '0;
        b        = '0;
        test_reset();
        test_decode_sweep();
        test_slt();
        test_multu();
        test_illegal();
        test_random();
        test_reset_mid_mul();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
